// File: rtl/des_final_transp_tx.sv
// DES output stage: final swap (R16||L16), inverse initial permutation,
// and a valid/ready beat serializer for the 64-bit ciphertext.
// Bit convention: vector index i carries DES bit i+1.
module des_final_transp_tx #(
  parameter int CIPHER_WIDTH = 64,  // only 64 is meaningful
  parameter int OUT_WIDTH    = 8    // 8, 16, 32 or 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_l,
  input  logic [31:0]          in_r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last
);

  localparam int BEATS = CIPHER_WIDTH / OUT_WIDTH;
  localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BEATS - 1);

  // IP^-1: c[i] = p[FP[i]-1]
  localparam int FP [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
  };

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [CNTW-1:0]         cnt;
  logic [CIPHER_WIDTH-1:0] sr;       // sr[CIPHER_WIDTH-1-i] = c[i]; next beat sits at the top
  logic [CIPHER_WIDTH-1:0] perm;
  logic [CIPHER_WIDTH-1:0] sr_shift;
  logic [63:0]             p;
  logic                    accept;

  // Final swap: R16 occupies the low half (DES bits 1..32).
  assign p = {in_l, in_r};

  // Permutation is stored pre-reversed so each beat is a plain top slice,
  // which puts DES bit 1 at the MSB of beat 0.
  for (genvar i = 0; i < 64; i++) begin : g_fp
    assign perm[CIPHER_WIDTH-1-i] = p[FP[i]-1];
  end

  if (BEATS > 1) begin : g_shift
    assign sr_shift = {sr[CIPHER_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
  end else begin : g_noshift
    assign sr_shift = '0;
  end

  // Ready comes straight from out_ready on the last beat so a new block can
  // be taken in the same cycle the previous one finishes.
  assign in_ready = (state == IDLE) || (out_last && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_data = sr[CIPHER_WIDTH-1 -: OUT_WIDTH];

  // Serializer FSM with registered valid/last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      state     <= SEND;
      cnt       <= '0;
      sr        <= perm;
      out_valid <= 1'b1;
      out_last  <= (BEATS == 1);
    end else if (state == SEND && out_ready) begin
      if (out_last) begin
        state     <= IDLE;
        cnt       <= '0;
        sr        <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        cnt      <= cnt + 1'b1;
        sr       <= sr_shift;
        out_last <= ((cnt + 1'b1) == LAST_CNT);
      end
    end
  end

endmodule

// File: tb/tb_des_final_transp_tx.sv
// Scoreboard bench for des_final_transp_tx: an 8-bit-beat instance (a) and a
// 64-bit-beat instance (b). Stimulus pushes expected beats; negedge monitors
// pop and compare on every accepted beat.
module tb_des_final_transp_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_a, in_valid_b;
  logic        in_ready_a, in_ready_b;
  logic [31:0] in_l, in_r;
  logic        out_ready;
  logic        out_valid_a, out_valid_b;
  logic        out_last_a, out_last_b;
  logic [7:0]  out_data_a;
  logic [63:0] out_data_b;

  always #5 clk = ~clk;

  des_final_transp_tx #(.CIPHER_WIDTH(64), .OUT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_l(in_l), .in_r(in_r), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_last(out_last_a));

  des_final_transp_tx #(.CIPHER_WIDTH(64), .OUT_WIDTH(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_l(in_l), .in_r(in_r), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_last(out_last_b));

  typedef struct { logic [63:0] d; logic last; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int n_cmp = 0;
  int n_bad = 0;

  localparam int IP [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] C2 = 64'h0123456789ABCDEF;

  logic [31:0] v1_l, v1_r, v2_l, v2_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[31-i];
    return y;
  endfunction

  function automatic logic [63:0] bitrev64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[63-i];
    return y;
  endfunction

  // Push the first n byte beats of ciphertext c (MSB byte first).
  task automatic push_a(input logic [63:0] c, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.d    = {56'h0, c[63-8*k -: 8]};
      e.last = (k == 7);
      qa.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input string nm);
    int k;
    k = 0;
    while (qa.size() != 0 && k < 40) begin
      step();
      k++;
    end
    chk(nm, 64'(qa.size()), 64'd0);
    chk({nm, "_idle"}, {63'h0, out_valid_a}, 64'd0);
  endtask

  // Present a block to dut_a for one accepted cycle.
  task automatic send_a(input logic [31:0] l, input logic [31:0] r);
    in_l = l; in_r = r; in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid_a && out_ready) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL beat_a_unexpected: got %h, expected no beat", out_data_a);
      end else begin
        e = qa.pop_front();
        chk("beat_a_data", {56'h0, out_data_a}, e.d);
        chk("beat_a_last", {63'h0, out_last_a}, {63'h0, e.last});
      end
    end
  end

  // Monitor for the 64-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid_b && out_ready) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL beat_b_unexpected: got %h, expected no beat", out_data_b);
      end else begin
        e = qb.pop_front();
        chk("beat_b_data", out_data_b, e.d);
        chk("beat_b_last", {63'h0, out_last_b}, {63'h0, e.last});
      end
    end
  end

  initial begin
    logic [63:0] xv, t;
    exp_t e;

    rst_n = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_l = '0; in_r = '0; out_ready = 1'b0;

    v1_l = bitrev32(32'h43423234);
    v1_r = bitrev32(32'h0A4CD995);
    xv = bitrev64(C2);
    for (int i = 0; i < 64; i++) t[i] = xv[IP[i]-1];
    v2_r = t[31:0];
    v2_l = t[63:32];

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", {63'h0, out_valid_a}, 64'd0);
    chk("rst_out_last",  {63'h0, out_last_a},  64'd0);
    chk("rst_out_data",  {56'h0, out_data_a},  64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  {63'h0, in_ready_a},  64'd1);
    step();

    // 1: known answer, full-rate sink
    out_ready = 1'b1;
    push_a(C1, 8);
    in_l = v1_l; in_r = v1_r; in_valid_a = 1'b1;
    #1;
    chk("t1_in_ready", {63'h0, in_ready_a}, 64'd1);
    step();
    in_valid_a = 1'b0;
    chk("t1_latency", {63'h0, out_valid_a}, 64'd1);
    drain_a("t1_drain");

    // 2: round trip through the initial transposition
    push_a(C2, 8);
    send_a(v2_l, v2_r);
    drain_a("t2_drain");

    // 3: backpressure at beat 2
    push_a(C1, 8);
    send_a(v1_l, v1_r);
    step();
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t3_hold_data",  {56'h0, out_data_a}, 64'h13);
      chk("t3_hold_valid", {63'h0, out_valid_a}, 64'd1);
      chk("t3_in_ready",   {63'h0, in_ready_a},  64'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t3_hold_data4", {56'h0, out_data_a}, 64'h13);
    drain_a("t3_drain");

    // 4: back-to-back, second block offered on the last beat of the first
    push_a(C1, 8);
    send_a(v1_l, v1_r);
    repeat (7) step();
    push_a(C2, 8);
    in_l = v2_l; in_r = v2_r; in_valid_a = 1'b1;
    #1;
    chk("t4_last",     {63'h0, out_last_a}, 64'd1);
    chk("t4_in_ready", {63'h0, in_ready_a}, 64'd1);
    step();
    in_valid_a = 1'b0;
    chk("t4_no_bubble", {63'h0, out_valid_a}, 64'd1);
    drain_a("t4_drain");

    // 5: reset after beat 3 has been delivered
    push_a(C1, 4);
    send_a(v1_l, v1_r);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("t5_valid_rst", {63'h0, out_valid_a}, 64'd0);
    chk("t5_data_rst",  {56'h0, out_data_a},  64'd0);
    chk("t5_last_rst",  {63'h0, out_last_a},  64'd0);
    @(posedge clk); @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("t5_in_ready", {63'h0, in_ready_a}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_no_beat", {63'h0, out_valid_a}, 64'd0);
    end
    chk("t5_q_empty", 64'(qa.size()), 64'd0);

    // 6: single 64-bit beat
    e.d = C1; e.last = 1'b1;
    qb.push_back(e);
    in_l = v1_l; in_r = v1_r; in_valid_b = 1'b1;
    #1;
    chk("t6_in_ready", {63'h0, in_ready_b}, 64'd1);
    step();
    in_valid_b = 1'b0;
    chk("t6_valid", {63'h0, out_valid_b}, 64'd1);
    chk("t6_last",  {63'h0, out_last_b},  64'd1);
    step();
    chk("t6_done",    {63'h0, out_valid_b}, 64'd0);
    chk("t6_q_empty", 64'(qb.size()), 64'd0);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
